mesh_term_src: RTL
==================

// Module: mesh_term_src
// PURPOSE
//  Source-side terminal FIFO feeding one external input port of the 4x4 mesh_gnrtr.
//  - Write side: the bench driver pushes packets into it.
//  - Read side: the mesh pulls them through the pndng_i_in / data_out_i_in / popin handshake.
//  - Reports push-at-full drops (overflow) and pop-at-empty (underflow) with the dropped
//    packet, plus saturating counters, so the scoreboard can reconcile injected vs. accepted.
// PARAMETERS
//  pckg_sz     40  packet width in bits; {target row, target col, mode, payload} per router lib
//  fifo_depth  4   storage entries; any value >= 2, not required to be a power of two
//  cnt_w       16  width of the tx_cnt / drop_cnt statistics counters
// PORTS
//  clk          in   1                    single clock; all logic on posedge
//  reset        in   1                    synchronous, active-high
//  push         in   1                    driver writes din this cycle
//  din          in   pckg_sz              packet to enqueue
//  full         out  1                    count == fifo_depth
//  count        out  $clog2(fifo_depth)+1 current occupancy
//  pndng        out  1                    count != 0; drives mesh pndng_i_in
//  data_out     out  pckg_sz              head entry (show-ahead); drives mesh data_out_i_in
//  popin        in   1                    mesh consumes head entry this cycle
//  overflow     out  1                    one-cycle pulse: push was dropped last cycle
//  ovf_data     out  pckg_sz              packet dropped by that push; held until next drop
//  underflow    out  1                    one-cycle pulse: popin seen last cycle while empty
//  tx_cnt       out  cnt_w                packets accepted by the mesh; saturating
//  drop_cnt     out  cnt_w                packets dropped at full; saturating
// BEHAVIOUR
//  Reset
//   - wr_ptr, rd_ptr, count, overflow, underflow, tx_cnt, drop_cnt and ovf_data are 0.
//   - Memory contents are not cleared. Reset has priority over push and popin in the same cycle.
//   - Reset mid-stream discards all queued packets; pndng is 0 the cycle after reset is asserted.
//  Storage
//   - Circular buffer of fifo_depth entries.
//   - Each pointer wraps from fifo_depth-1 to 0; the wrap must be explicit, not a natural
//     power-of-two rollover.
//  Read side
//   - Show-ahead: data_out = mem[rd_ptr] combinationally whenever pndng = 1.
//   - data_out = 0 when empty.
//   - popin with pndng = 1: rd_ptr advances at that edge; the next entry appears the following cycle.
//   - A packet pushed into an empty FIFO is visible on pndng/data_out one cycle after the push edge.
//     No fall-through in the same cycle.
//  Per-edge cases (p = push, q = popin)
//   - p, not full, no q:  write, count+1.
//   - q, not empty, no p: read, count-1, tx_cnt+1.
//   - p and q, 0 < count < depth: write and read, count unchanged, tx_cnt+1.
//   - p and q, full: pop frees the slot; push is accepted; count stays fifo_depth; no overflow.
//   - p, full, no q: push dropped; overflow = 1 next cycle; ovf_data <= din; drop_cnt+1.
//   - q, empty (with or without p): pop ignored; underflow = 1 next cycle.
//     A simultaneous push is accepted, count becomes 1, tx_cnt unchanged.
//  Flag rules
//   - overflow and underflow are single-cycle pulses.
//   - Back-to-back drops give back-to-back overflow pulses, and ovf_data updates every cycle.
//  Counters
//   - tx_cnt and drop_cnt stick at 2^cnt_w-1; they never wrap.
//   - count never exceeds fifo_depth and never goes below 0.
// TESTING
//  1. Reset, then 4 pushes 0xA1..0xA4 with popin=0
//     -> full=1, count=4, data_out=0xA1, overflow=0.
//  2. Full FIFO, push 0xBB with popin=0
//     -> next cycle overflow=1 for exactly 1 cycle, ovf_data=0xBB, drop_cnt=1, count=4.
//  3. Full FIFO, push 0xCC with popin=1 in the same cycle
//     -> no overflow, count=4, tx_cnt+1; drain order 0xA2,0xA3,0xA4,0xCC.
//  4. Empty FIFO, popin=1 with push 0xDD
//     -> underflow pulse, count=1, tx_cnt unchanged; data_out=0xDD next cycle.
//  5. fifo_depth=3, 10 push/pop pairs with values 1..10
//     -> pointers wrap correctly, output order 1..10, no flags asserted.
//  6. Reset asserted with count=3 and push=1
//     -> count=0, pndng=0, tx_cnt=0, drop_cnt=0 on the next cycle; pushed packet discarded.

Source files
------------

// File: rtl/mesh_term_src.sv
// mesh_term_src: source-side terminal FIFO feeding one mesh input port.
// Show-ahead circular buffer with drop/underflow reporting and saturating
// statistics counters for injected-vs-accepted reconciliation.
module mesh_term_src #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int cnt_w      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [pckg_sz-1:0]            din,
    output logic                          full,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          pndng,
    output logic [pckg_sz-1:0]            data_out,
    input  logic                          popin,
    output logic                          overflow,
    output logic [pckg_sz-1:0]            ovf_data,
    output logic                          underflow,
    output logic [cnt_w-1:0]              tx_cnt,
    output logic [cnt_w-1:0]              drop_cnt
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0]    LAST_PTR = PW'(fifo_depth - 1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(fifo_depth);
    localparam logic [cnt_w-1:0] STAT_MAX = {cnt_w{1'b1}};
    localparam logic [cnt_w-1:0] STAT_ONE = cnt_w'(1);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic               r_underflow;
    logic [pckg_sz-1:0] r_ovf_data;
    logic [cnt_w-1:0]   r_tx_cnt;
    logic [cnt_w-1:0]   r_drop_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_drop;
    logic               w_udf;
    logic [CW-1:0]      w_count_nxt;
    logic [cnt_w-1:0]   w_tx_nxt;
    logic [cnt_w-1:0]   w_drop_nxt;
    logic [pckg_sz-1:0] w_data_out;

    // Explicit wrap from the last slot back to zero (depth need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_do_pop  = popin && !w_empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign w_drop    = push && w_full && !popin;
    assign w_udf     = popin && w_empty;

    // Next occupancy and saturating statistics.
    always_comb begin
        w_count_nxt = r_count;
        w_tx_nxt    = r_tx_cnt;
        w_drop_nxt  = r_drop_cnt;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
        if (w_do_pop && (r_tx_cnt != STAT_MAX)) begin
            w_tx_nxt = r_tx_cnt + STAT_ONE;
        end else begin
            w_tx_nxt = r_tx_cnt;
        end
        if (w_drop && (r_drop_cnt != STAT_MAX)) begin
            w_drop_nxt = r_drop_cnt + STAT_ONE;
        end else begin
            w_drop_nxt = r_drop_cnt;
        end
    end

    // Show-ahead head entry; forced to zero while empty.
    always_comb begin
        w_data_out = {pckg_sz{1'b0}};
        if (w_empty) begin
            w_data_out = {pckg_sz{1'b0}};
        end else begin
            w_data_out = r_mem[r_rd_ptr];
        end
    end

    // Storage array write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !reset) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, flags and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_ovf_data  <= {pckg_sz{1'b0}};
            r_tx_cnt    <= {cnt_w{1'b0}};
            r_drop_cnt  <= {cnt_w{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_drop) begin
                r_ovf_data <= din;
            end
            r_count     <= w_count_nxt;
            r_overflow  <= w_drop;
            r_underflow <= w_udf;
            r_tx_cnt    <= w_tx_nxt;
            r_drop_cnt  <= w_drop_nxt;
        end
    end

    assign full      = w_full;
    assign count     = r_count;
    assign pndng     = !w_empty;
    assign data_out  = w_data_out;
    assign overflow  = r_overflow;
    assign ovf_data  = r_ovf_data;
    assign underflow = r_underflow;
    assign tx_cnt    = r_tx_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
